// File: rtl/input_cmd_pkg.sv
// Shared types and command encodings for the player-input command arbiter.
package input_cmd_pkg;

  typedef enum logic [1:0] {
    SRC_UART = 2'd0,
    SRC_BTN  = 2'd1,
    SRC_PAN  = 2'd2
  } cmd_src_t;

  localparam logic [7:0] CMD_HIT_PRESS   = 8'hF0;
  localparam logic [7:0] CMD_HIT_RELEASE = 8'hF1;
  localparam logic [7:0] CMD_PAN_LEFT    = 8'hE0;
  localparam logic [7:0] CMD_PAN_RIGHT   = 8'hE1;

  // Round-robin successor: UART -> BTN -> PAN -> UART.
  function automatic cmd_src_t next_src(input cmd_src_t src);
    cmd_src_t nxt;
    case (src)
      SRC_UART: nxt = SRC_BTN;
      SRC_BTN:  nxt = SRC_PAN;
      default:  nxt = SRC_UART;
    endcase
    return nxt;
  endfunction

  // First requester at or after ptr; req bit index equals the cmd_src_t value.
  // Only meaningful when at least one request bit is set.
  function automatic cmd_src_t rr_pick(input logic [2:0] req, input cmd_src_t ptr);
    cmd_src_t pick;
    case (ptr)
      SRC_UART: begin
        if (req[0])      pick = SRC_UART;
        else if (req[1]) pick = SRC_BTN;
        else             pick = SRC_PAN;
      end
      SRC_BTN: begin
        if (req[1])      pick = SRC_BTN;
        else if (req[2]) pick = SRC_PAN;
        else             pick = SRC_UART;
      end
      default: begin
        if (req[2])      pick = SRC_PAN;
        else if (req[0]) pick = SRC_UART;
        else             pick = SRC_BTN;
      end
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/cmd_byte_fifo.sv
// Small show-ahead byte FIFO; head byte is visible on data_out while not empty.
module cmd_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push_in,
  input  logic [7:0]  data_in,
  input  logic        pop_in,
  output logic [7:0]  data_out,
  output logic        full_out,
  output logic        empty_out,
  output logic [AW:0] level_out
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok_s, pop_ok_s;

  assign full_out  = (level_q == DEPTH_L);
  assign empty_out = (level_q == '0);
  assign data_out  = mem_q[rd_ptr_q];
  assign level_out = level_q;

  // Accept pushes when space exists or a pop frees a slot this cycle; update pointers and level.
  always_comb begin
    pop_ok_s  = pop_in && !empty_out;
    push_ok_s = push_in && (!full_out || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

endmodule

// File: rtl/input_cmd_arbiter.sv
// Merges UART bytes, debounced hit-button edges and frame-paced pan events
// into one valid/ready command byte stream using round-robin arbitration.
module input_cmd_arbiter
  import input_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 742500,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [7:0]    uart_data_in,
  input  logic          uart_valid_in,
  input  logic          hit_btn_in,
  input  logic          pan_left_in,
  input  logic          pan_right_in,
  input  logic          new_frame_in,
  input  logic          cmd_ready_in,
  output logic [7:0]    cmd_data_out,
  output logic          cmd_valid_out,
  output logic [1:0]    cmd_src_out,
  output logic [LW-1:0] fifo_level_out,
  output logic [7:0]    drop_count_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_t;

  logic [1:0]    hit_sync_q, pan_l_sync_q, pan_r_sync_q;
  logic          btn_db_q, btn_db_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          btn_pend_q, btn_pend_d, pan_pend_q, pan_pend_d;
  logic [7:0]    btn_data_q, btn_data_d, pan_data_q, pan_data_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  out_state_t    state_q, state_d;
  cmd_src_t      rr_q, rr_d, win_s, cmd_src_q, cmd_src_d;
  logic [7:0]    cmd_data_q, cmd_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    req_s;
  logic          arb_en_s, grant_s, pop_uart_s, clr_btn_s, clr_pan_s;
  logic          rise_s, fall_s, pan_evt_s, btn_drop_s, pan_drop_s, fifo_drop_s;
  logic [8:0]    drop_sum_s;
  logic [7:0]    fifo_data_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [LW-1:0] fifo_level_s;

  cmd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (uart_valid_in),
    .data_in   (uart_data_in),
    .pop_in    (pop_uart_s),
    .data_out  (fifo_data_s),
    .full_out  (fifo_full_s),
    .empty_out (fifo_empty_s),
    .level_out (fifo_level_s)
  );

  // Round-robin grant and next output-stage contents.
  always_comb begin
    req_s       = {pan_pend_q, btn_pend_q, ~fifo_empty_s};
    arb_en_s    = (state_q == ST_EMPTY) || cmd_ready_in;
    win_s       = rr_pick(req_s, rr_q);
    grant_s     = arb_en_s && (req_s != 3'b000);
    state_d     = state_q;
    rr_d        = rr_q;
    cmd_data_d  = cmd_data_q;
    cmd_src_d   = cmd_src_q;
    cmd_valid_d = cmd_valid_q;
    if (grant_s) begin
      state_d     = ST_FULL;
      cmd_valid_d = 1'b1;
      cmd_src_d   = win_s;
      rr_d        = next_src(win_s);
      case (win_s)
        SRC_UART: cmd_data_d = fifo_data_s;
        SRC_BTN:  cmd_data_d = btn_data_q;
        default:  cmd_data_d = pan_data_q;
      endcase
    end else if (arb_en_s) begin
      state_d     = ST_EMPTY;
      cmd_valid_d = 1'b0;
    end else begin
      state_d     = state_q;
    end
    pop_uart_s = grant_s && (win_s == SRC_UART);
    clr_btn_s  = grant_s && (win_s == SRC_BTN);
    clr_pan_s  = grant_s && (win_s == SRC_PAN);
  end

  // Debounce, pending-event capture and saturating drop accounting.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    if (hit_sync_q[1] != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = hit_sync_q[1];
        db_cnt_d = '0;
        rise_s   = hit_sync_q[1];
        fall_s   = ~hit_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end

    // A pending flag being granted this cycle frees its slot, so a new event is not a drop.
    btn_pend_d = btn_pend_q & ~clr_btn_s;
    btn_data_d = btn_data_q;
    btn_drop_s = 1'b0;
    if (rise_s || fall_s) begin
      btn_drop_s = btn_pend_q & ~clr_btn_s;
      btn_pend_d = 1'b1;
      btn_data_d = rise_s ? CMD_HIT_PRESS : CMD_HIT_RELEASE;
    end else begin
      btn_drop_s = 1'b0;
    end

    pan_evt_s  = new_frame_in && (pan_l_sync_q[1] ^ pan_r_sync_q[1]);
    pan_pend_d = pan_pend_q & ~clr_pan_s;
    pan_data_d = pan_data_q;
    pan_drop_s = 1'b0;
    if (pan_evt_s) begin
      pan_drop_s = pan_pend_q & ~clr_pan_s;
      pan_pend_d = 1'b1;
      pan_data_d = pan_l_sync_q[1] ? CMD_PAN_LEFT : CMD_PAN_RIGHT;
    end else begin
      pan_drop_s = 1'b0;
    end

    fifo_drop_s = uart_valid_in && fifo_full_s && !pop_uart_s;
    drop_sum_s  = {1'b0, drop_cnt_q} + 9'(fifo_drop_s) + 9'(btn_drop_s) + 9'(pan_drop_s);
    if (drop_sum_s > 9'd255) begin
      drop_cnt_d = 8'd255;
    end else begin
      drop_cnt_d = drop_sum_s[7:0];
    end
  end

  // Synchronizers, debounce/pending state and the registered output-stage FSM.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_sync_q   <= 2'b00;
      pan_l_sync_q <= 2'b00;
      pan_r_sync_q <= 2'b00;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      btn_pend_q   <= 1'b0;
      btn_data_q   <= 8'h00;
      pan_pend_q   <= 1'b0;
      pan_data_q   <= 8'h00;
      drop_cnt_q   <= 8'h00;
      state_q      <= ST_EMPTY;
      rr_q         <= SRC_UART;
      cmd_data_q   <= 8'h00;
      cmd_src_q    <= SRC_UART;
      cmd_valid_q  <= 1'b0;
    end else begin
      hit_sync_q   <= {hit_sync_q[0], hit_btn_in};
      pan_l_sync_q <= {pan_l_sync_q[0], pan_left_in};
      pan_r_sync_q <= {pan_r_sync_q[0], pan_right_in};
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      btn_pend_q   <= btn_pend_d;
      btn_data_q   <= btn_data_d;
      pan_pend_q   <= pan_pend_d;
      pan_data_q   <= pan_data_d;
      drop_cnt_q   <= drop_cnt_d;
      state_q      <= state_d;
      rr_q         <= rr_d;
      cmd_data_q   <= cmd_data_d;
      cmd_src_q    <= cmd_src_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

  assign cmd_data_out   = cmd_data_q;
  assign cmd_valid_out  = cmd_valid_q;
  assign cmd_src_out    = cmd_src_q;
  assign fifo_level_out = fifo_level_s;
  assign drop_count_out = drop_cnt_q;

endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Scoreboard bench for input_cmd_arbiter (FIFO_DEPTH=4, DEBOUNCE_CYCLES=4).
module tb_input_cmd_arbiter;
  import input_cmd_pkg::*;

  localparam int FD = 4;
  localparam int DB = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [7:0]    uart_data_in = 8'h00;
  logic          uart_valid_in = 1'b0;
  logic          hit_btn_in = 1'b0;
  logic          pan_left_in = 1'b0;
  logic          pan_right_in = 1'b0;
  logic          new_frame_in = 1'b0;
  logic          cmd_ready_in = 1'b1;
  logic [7:0]    cmd_data_out;
  logic          cmd_valid_out;
  logic [1:0]    cmd_src_out;
  logic [LW-1:0] fifo_level_out;
  logic [7:0]    drop_count_out;

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_drop = 0;
  logic [9:0] sb_q[$];
  logic [9:0] mon_item;

  input_cmd_arbiter #(.FIFO_DEPTH(FD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .uart_data_in   (uart_data_in),
    .uart_valid_in  (uart_valid_in),
    .hit_btn_in     (hit_btn_in),
    .pan_left_in    (pan_left_in),
    .pan_right_in   (pan_right_in),
    .new_frame_in   (new_frame_in),
    .cmd_ready_in   (cmd_ready_in),
    .cmd_data_out   (cmd_data_out),
    .cmd_valid_out  (cmd_valid_out),
    .cmd_src_out    (cmd_src_out),
    .fifo_level_out (fifo_level_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    uart_data_in  = b;
    uart_valid_in = 1'b1;
    tick();
    uart_valid_in = 1'b0;
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic expect_cmd(input logic [1:0] src, input logic [7:0] data);
    sb_q.push_back({src, data});
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) tick();
    chk_eq(tag, 32'(sb_q.size()), 32'd0);
    ticks(2);
  endtask

  // Every accepted transfer is compared against the head of the scoreboard.
  always @(negedge clk_in) begin
    if (rst_in && cmd_valid_out && cmd_ready_in) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_xfer", 32'(cmd_data_out), 32'hFFFF_FFFF);
      end else begin
        mon_item = sb_q.pop_front();
        chk_eq("xfer_data", 32'(cmd_data_out), 32'(mon_item[7:0]));
        chk_eq("xfer_src", 32'(cmd_src_out), 32'(mon_item[9:8]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(3);
    chk_eq("rst_valid", 32'(cmd_valid_out), 32'd0);
    chk_eq("rst_data", 32'(cmd_data_out), 32'd0);
    chk_eq("rst_src", 32'(cmd_src_out), 32'd0);
    chk_eq("rst_level", 32'(fifo_level_out), 32'd0);
    chk_eq("rst_drop", 32'(drop_count_out), 32'd0);
    rst_in = 1'b1;
    ticks(2);

    // Single UART byte: valid two cycles after the strobe
    expect_cmd(2'd0, 8'h41);
    push_byte(8'h41);
    chk_eq("lat_valid_early", 32'(cmd_valid_out), 32'd0);
    chk_eq("lat_level_1", 32'(fifo_level_out), 32'd1);
    tick();
    chk_eq("lat_valid", 32'(cmd_valid_out), 32'd1);
    chk_eq("lat_data", 32'(cmd_data_out), 32'h41);
    chk_eq("lat_level_0", 32'(fifo_level_out), 32'd0);
    wait_drain("drain_t1", 20);
    chk_eq("idle_valid", 32'(cmd_valid_out), 32'd0);

    // FIFO overflow while consumer stalls
    cmd_ready_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) expect_cmd(2'd0, 8'(i));
      push_byte(8'(i));
    end
    exp_drop = exp_drop + 1;
    chk_eq("ovf_level", 32'(fifo_level_out), 32'd4);
    chk_eq("ovf_drop", 32'(drop_count_out), 32'(exp_drop));
    chk_eq("ovf_hold_valid", 32'(cmd_valid_out), 32'd1);
    chk_eq("ovf_hold_data", 32'(cmd_data_out), 32'h01);
    cmd_ready_in = 1'b1;
    wait_drain("drain_t2", 40);
    chk_eq("ovf_level_end", 32'(fifo_level_out), 32'd0);

    // Round-robin among UART, button and pan
    cmd_ready_in = 1'b0;
    expect_cmd(2'd0, 8'h11);
    expect_cmd(2'd1, CMD_HIT_PRESS);
    expect_cmd(2'd2, CMD_PAN_LEFT);
    expect_cmd(2'd0, 8'h22);
    expect_cmd(2'd0, 8'h33);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    hit_btn_in = 1'b1;
    ticks(8);
    pan_left_in = 1'b1;
    ticks(3);
    frame_pulse();
    pan_left_in = 1'b0;
    ticks(2);
    chk_eq("rr_level", 32'(fifo_level_out), 32'd2);
    chk_eq("rr_hold_data", 32'(cmd_data_out), 32'h11);
    chk_eq("rr_drop", 32'(drop_count_out), 32'(exp_drop));
    cmd_ready_in = 1'b1;
    wait_drain("drain_t3", 40);
    expect_cmd(2'd1, CMD_HIT_RELEASE);
    hit_btn_in = 1'b0;
    wait_drain("drain_t3_rel", 40);

    // Button glitch rejected; clean press/release gives F0 then F1
    hit_btn_in = 1'b1;
    ticks(2);
    hit_btn_in = 1'b0;
    ticks(12);
    chk_eq("glitch_valid", 32'(cmd_valid_out), 32'd0);
    chk_eq("glitch_drop", 32'(drop_count_out), 32'(exp_drop));
    expect_cmd(2'd1, CMD_HIT_PRESS);
    expect_cmd(2'd1, CMD_HIT_RELEASE);
    hit_btn_in = 1'b1;
    ticks(8);
    hit_btn_in = 1'b0;
    ticks(8);
    wait_drain("drain_t4", 40);

    // Both pan switches high: no events
    pan_left_in  = 1'b1;
    pan_right_in = 1'b1;
    ticks(3);
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      ticks(2);
    end
    ticks(3);
    chk_eq("pan_both_valid", 32'(cmd_valid_out), 32'd0);
    // Pan right across two frames while output is stalled: overwrite counts as drop
    cmd_ready_in = 1'b0;
    pan_left_in  = 1'b0;
    expect_cmd(2'd0, 8'h77);
    expect_cmd(2'd2, CMD_PAN_RIGHT);
    push_byte(8'h77);
    ticks(3);
    frame_pulse();
    ticks(2);
    frame_pulse();
    tick();
    exp_drop = exp_drop + 1;
    chk_eq("pan_drop", 32'(drop_count_out), 32'(exp_drop));
    chk_eq("pan_hold_data", 32'(cmd_data_out), 32'h77);
    cmd_ready_in = 1'b1;
    wait_drain("drain_t5", 40);
    pan_right_in = 1'b0;
    ticks(3);

    // Asynchronous reset mid-transfer
    cmd_ready_in = 1'b0;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    tick();
    chk_eq("pre_rst_valid", 32'(cmd_valid_out), 32'd1);
    chk_eq("pre_rst_level", 32'(fifo_level_out), 32'd3);
    sb_q.delete();
    #2;
    rst_in = 1'b0;
    #1;
    chk_eq("mid_rst_valid", 32'(cmd_valid_out), 32'd0);
    chk_eq("mid_rst_level", 32'(fifo_level_out), 32'd0);
    chk_eq("mid_rst_drop", 32'(drop_count_out), 32'd0);
    exp_drop = 0;
    ticks(2);
    rst_in = 1'b1;
    cmd_ready_in = 1'b1;
    tick();
    pan_left_in = 1'b1;
    ticks(3);
    expect_cmd(2'd0, 8'h5A);
    expect_cmd(2'd2, CMD_PAN_LEFT);
    new_frame_in = 1'b1;
    push_byte(8'h5A);
    new_frame_in = 1'b0;
    pan_left_in  = 1'b0;
    wait_drain("drain_t6", 40);
    chk_eq("post_rst_drop", 32'(drop_count_out), 32'(exp_drop));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
